// File: rtl/aap_fetch_stage.sv
// AAP instruction fetch: PC, synchronous word reads, 4-word FIFO,
// 16/32-bit instruction assembly and redirect flush.
module aap_fetch_stage #(
    parameter int                  PC_WIDTH = 24,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                speedy_clock,
    input  logic                reset,
    output logic                mem_rd_en,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_target,
    output logic                fetch_valid,
    input  logic                decode_ready,
    output logic [31:0]         fetchoutput,
    output logic                fetch_len32,
    output logic [PC_WIDTH-1:0] fetch_pc
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [2:0]          count_q, count_d;
    logic                inflight_q, inflight_d;
    logic [PC_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic [15:0]         data_q [4];
    logic [15:0]         data_d [4];
    logic [PC_WIDTH-1:0] tag_q [4];
    logic [PC_WIDTH-1:0] tag_d [4];

    logic       head_len32;
    logic       issue;
    logic       push;
    logic       fire;
    logic [2:0] pop_n;
    logic [2:0] wr_idx;
    logic [2:0] src_idx;

    always_comb begin
        head_len32  = data_q[0][15];
        fetch_valid = !redirect_valid &&
                      ((count_q >= 3'd1 && !head_len32) ||
                       (count_q >= 3'd2 && head_len32));
        // Reset gates the request so it drops the instant reset asserts
        issue       = !reset && !redirect_valid &&
                      ((count_q + {2'b0, inflight_q}) < 3'd4);
        mem_rd_en   = issue;
        mem_addr    = pc_q;
        fetchoutput = {head_len32 ? data_q[1] : 16'h0, data_q[0]};
        fetch_len32 = head_len32;
        fetch_pc    = tag_q[0];
    end

    always_comb begin
        fire   = fetch_valid && decode_ready;
        pop_n  = fire ? (head_len32 ? 3'd2 : 3'd1) : 3'd0;
        push   = inflight_q && !redirect_valid;
        wr_idx = count_q - pop_n;
        for (int i = 0; i < 4; i++) begin
            src_idx = 3'(i) + pop_n;
            if (src_idx < 3'd4) begin
                data_d[i] = data_q[src_idx[1:0]];
                tag_d[i]  = tag_q[src_idx[1:0]];
            end else begin
                data_d[i] = data_q[i];
                tag_d[i]  = tag_q[i];
            end
        end
        // Issue rule keeps wr_idx below 4 whenever a response is due
        if (push) begin
            data_d[wr_idx[1:0]] = mem_rdata;
            tag_d[wr_idx[1:0]]  = infl_addr_q;
        end
        if (redirect_valid) begin
            count_d = 3'd0;
            pc_d    = redirect_target;
        end else begin
            count_d = count_q - pop_n + {2'b0, push};
            pc_d    = issue ? pc_q + 1'b1 : pc_q;
        end
        inflight_d  = issue;
        infl_addr_d = pc_q;
    end

    always_ff @(posedge speedy_clock or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            count_q     <= 3'd0;
            inflight_q  <= 1'b0;
            infl_addr_q <= RESET_PC;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= 16'h0;
                tag_q[i]  <= RESET_PC;
            end
        end else begin
            pc_q        <= pc_d;
            count_q     <= count_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

endmodule

// File: doc/aap_fetch_stage.md
# aap_fetch_stage

Instruction fetch stage for the AAP pipeline. It sits directly upstream of `sixteenbitdecoder` and drives its `fetchoutput`. It keeps the fetch PC, issues word reads to a synchronous instruction memory, and buffers returned 16-bit words in a 4-entry word FIFO. It assembles 16- or 32-bit instructions and hands them to decode over a valid/ready handshake; a redirect input flushes the stage for branches.

## Interface
- `PC_WIDTH`, 24: width of the word address / PC.
- `RESET_PC`, 0: first fetch address after reset.
- `speedy_clock`  in  1  pipeline clock (divided from CLOCK_50 by SpeedClock)
- `reset`  in  1  asynchronous, active-high reset
- `mem_rd_en`  out  1  read request this cycle
- `mem_addr`  out  PC_WIDTH  word address of the request
- `mem_rdata`  in  16  read data, valid exactly 1 cycle after `mem_rd_en`
- `redirect_valid`  in  1  branch/jump redirect
- `redirect_target`  in  PC_WIDTH  new fetch word address
- `fetch_valid`  out  1  `fetchoutput` holds a complete instruction
- `decode_ready`  in  1  decoder accepts this cycle
- `fetchoutput`  out  32  instruction: first word in [15:0], second word in [31:16] (zero for 16-bit)
- `fetch_len32`  out  1  1 = 32-bit instruction
- `fetch_pc`  out  PC_WIDTH  word address of the instruction's first word

## Operation
- The clock is `speedy_clock` and the reset is asynchronous and active-high (`reset`). Reset values: `pc_fetch`=RESET_PC, FIFO empty (count 0), in-flight flag 0, `mem_rd_en`=0, `mem_addr`=RESET_PC, `fetch_valid`=0, `fetchoutput`=0, `fetch_len32`=0, `fetch_pc`=RESET_PC.
- Issue rule: `mem_rd_en`=1 when `redirect_valid`=0 and (count + inflight) < 4. Use the current count, ignoring any pop in the same cycle. `mem_addr`=`pc_fetch`.
  - On issue, `pc_fetch` increments by 1 modulo 2^PC_WIDTH.
  - On issue, the in-flight flag is set for the next cycle.
- Response: in the cycle after an issue, `mem_rdata` is pushed into the FIFO tagged with its address, unless the response was cancelled by a redirect.
- Length rule: a head word with bit 15 = 0 is a 16-bit instruction. A head word with bit 15 = 1 is the first half of a 32-bit instruction.
- Assembly:
  - `fetch_valid`=1 when no redirect is present and either count ≥ 1 with head bit15 = 0, or count ≥ 2 with head bit15 = 1.
  - `fetchoutput` = {16'h0, head} for a 16-bit instruction, or {head+1, head} for a 32-bit instruction.
  - `fetch_pc` = the head's tag.
  - When `fetch_valid`=0, `fetchoutput`, `fetch_len32` and `fetch_pc` still reflect the head, but are don't-care for decode.
- Pop: when `fetch_valid` && `decode_ready`, the FIFO pops 1 word (16-bit) or 2 words (32-bit) at the clock edge. A push and a pop in the same cycle are both performed.
- Redirect (`redirect_valid`=1) has priority over everything else:
  - `fetch_valid` is forced 0 and no pop occurs.
  - `mem_rd_en` is 0.
  - The FIFO is flushed to count 0.
  - Any read issued in the previous cycle is discarded on arrival.
  - `pc_fetch` is loaded with `redirect_target`.
- Consecutive redirect cycles: the last target wins.
- Wrap-around: addresses wrap modulo 2^PC_WIDTH. A 32-bit instruction at the top address takes its second word from address 0.
- FIFO full: count + inflight never exceeds 4, so no overflow is possible. A FIFO holding 4 words with a stalled decoder stops issuing.
- A lone 32-bit first half (count = 1) holds `fetch_valid`=0 until the second word arrives.

## Timing
- Reset release: `mem_rd_en`=1 with addr RESET_PC at the first edge out of reset (cycle 0). Data is pushed at the end of cycle 1. The first `fetch_valid` is in cycle 2 (2-cycle fetch latency).
- Steady state with `decode_ready`=1: one 16-bit instruction per cycle, or one 32-bit instruction every 2 cycles.
- Redirect asserted in cycle N:
  - First read to the target in cycle N+1.
  - Target instruction valid in cycle N+3 (16-bit), or N+4 (32-bit).
- `decode_ready` may toggle arbitrarily. Outputs stay stable while `fetch_valid`=1 and `decode_ready`=0, unless a redirect occurs.
- Reset mid-operation clears the stage immediately (asynchronously). Any memory response arriving afterwards is ignored.

## Test plan
- Reset, RESET_PC=0x10, memory returns 16-bit words 0x0001,0x0002,0x0003, decode always ready -> `mem_addr` 0x10,0x11,0x12 on cycles 0,1,2; `fetch_valid` from cycle 2; `fetchoutput` 0x00000001,0x00000002,0x00000003 with `fetch_pc` 0x10,0x11,0x12.
- Memory at 0x20 holds 0x8123 then 0x4567, decode ready -> one transfer: `fetchoutput`=0x45678123, `fetch_len32`=1, `fetch_pc`=0x20. `fetch_valid` stays 0 while only 0x8123 is buffered.
- `decode_ready`=0 for 10 cycles after reset -> exactly 4 reads issued (addr 0..3), then `mem_rd_en` stays 0. The head output remains stable. On release, the instructions drain in order with no loss or duplication.
- Redirect to 0x100 while 3 words are buffered and 1 read is in flight -> `fetch_valid`=0 in the redirect cycle. The in-flight word is dropped. The next `fetch_pc` is 0x100, with `fetch_valid` at N+3.
- PC_WIDTH=4, redirect to 0xF, where word 0xF=0x8AAA and word 0x0=0x0BBB -> `fetchoutput`=0x0BBB8AAA, `fetch_pc`=0xF. The next read address is 0x1.
- Assert `reset` asynchronously mid-stream with a 32-bit half buffered -> `fetch_valid`=0 and `mem_rd_en`=0 immediately. After release, fetch restarts at RESET_PC per the first scenario.
